csr_counters: RTL and testbench
===============================

CSR_COUNTERS -- requirements
Module: csr_counters

Interface
REQ-001 The block SHALL have parameter NUM_HPM, default 4, number of hardware performance counters (range 1..29, counters 3..NUM_HPM+2).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 64, implemented counter width (range 32..64).
REQ-003 The block SHALL have parameter TIME_DIV, default 1, clock cycles per time tick (range 1..256).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 csr_req  input  1  CSR access strobe, one access per cycle.
REQ-007 csr_addr  input  12  CSR address.
REQ-008 csr_op  input  2  00 read-only, 01 RW, 10 RS (set bits), 11 RC (clear bits).
REQ-009 csr_wdata  input  32  write or mask operand.
REQ-010 csr_rdata  output  32  read data (old value).
REQ-011 csr_illegal  output  1  access illegal; no state change.
REQ-012 instret_inc  input  1  one instruction retired this cycle.
REQ-013 hpm_event  input  NUM_HPM  bit n = event for counter n+3 this cycle.

Function
REQ-014 Map SHALL be: 0xC00/0xC80 cycle lo/hi (RO); 0xC01/0xC81 time lo/hi (RO); 0xC02/0xC82 instret lo/hi (RO); 0xC03+n/0xC83+n hpmcounter lo/hi (RO); 0xB00/0xB80 mcycle lo/hi (RW); 0xB02/0xB82 minstret lo/hi (RW); 0xB03+n/0xB83+n mhpmcounter lo/hi (RW); 0x320 mcountinhibit (RW).
REQ-015 RO aliases and M-mode names SHALL access the same physical counter.
REQ-016 Any other address, including HPM index n >= NUM_HPM, SHALL assert csr_illegal and return csr_rdata = 0.
REQ-017 csr_rdata and csr_illegal SHALL be combinational from current state; both SHALL be 0 when csr_req = 0.
REQ-018 Hi-half reads SHALL return counter bits [CNT_WIDTH-1:32], zero-extended; if CNT_WIDTH = 32 they SHALL read 0.
REQ-019 A write SHALL occur when csr_req=1, the access is legal, and either csr_op=01, or csr_op is 10/11 with csr_wdata != 0.
REQ-020 New value SHALL be: RW wdata; RS old|wdata; RC old&~wdata. It SHALL be applied at the next rising edge.
REQ-021 csr_op=00, or RS/RC with wdata=0, to any mapped address (RO included) SHALL be a legal read with no write.
REQ-022 A write attempt per REQ-019 to an RO address SHALL assert csr_illegal with no state change.
REQ-023 A lo-half write SHALL update bits [31:0] only; a hi-half write SHALL update bits [CNT_WIDTH-1:32] only; unimplemented bits SHALL be dropped.
REQ-024 mcountinhibit bits SHALL be: bit0 CY, bit2 IR, bit(3+n) HPM n. Bit1 and bits above NUM_HPM+2 SHALL read 0 and ignore writes.
REQ-025 cycle SHALL increment by 1 every clock unless mcountinhibit[0]=1.
REQ-026 instret SHALL increment when instret_inc=1 and mcountinhibit[2]=0.
REQ-027 hpm n SHALL increment when hpm_event[n]=1 and mcountinhibit[3+n]=0.
REQ-028 Prescaler SHALL count 0..TIME_DIV-1 every clock and wrap to 0; time SHALL increment on the cycle the prescaler wraps. time is not inhibitable and not writable.
REQ-029 All counters SHALL wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-030 When a CSR write and an increment of the same counter fall in one cycle, the written value SHALL be stored and that cycle's increment dropped; the untouched half keeps its pre-increment value.
REQ-031 A write to mcountinhibit SHALL take effect from the following cycle; the current cycle's increments use the old value.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately clear all counters, the prescaler and mcountinhibit to 0, including mid-access; writes in flight are discarded.
REQ-033 During reset, csr_rdata SHALL be 0 and csr_illegal SHALL be 0.
REQ-034 The first increment SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-035 Release reset, idle 10 cycles, read 0xC00 -> 10; read 0xC80 -> 0; read 0xC02 -> 0.
REQ-036 RW 0xB00 = 0xFFFFFFFF, then RW 0xB80 = 0x0; next cycle read 0xC00 -> 0x00000000 and 0xC80 -> 0x00000001 (carry).
REQ-037 RW 0x320 = 0x5, pulse instret_inc 3 cycles, then read 0xB00/0xB02 -> unchanged; RC 0x320 mask 0x4 -> subsequent instret_inc counts.
REQ-038 TIME_DIV=4: after 16 cycles from reset, 0xC01 -> 4.
REQ-039 Checks: RW 0xC00 -> csr_illegal=1 with cycle unaffected; RS 0xC00 wdata=0 -> legal; read 0xB03+NUM_HPM -> illegal, rdata 0.
REQ-040 RW 0xB02 = 7 with instret_inc=1 in the same cycle -> next read 7; hpm_event[0] held 5 cycles -> 0xC03 reads 5.

Source files
------------

// File: rtl/csr_counters.sv
// Machine/user performance counter CSR block: cycle, time, instret and
// NUM_HPM event counters with 32-bit lo/hi access and mcountinhibit.
module csr_counters #(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_req,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               instret_inc,
  input  logic [NUM_HPM-1:0] hpm_event
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CYCLE,
    SEL_TIME,
    SEL_INSTRET,
    SEL_HPM,
    SEL_INHIBIT
  } sel_e;

  // Implemented inhibit bits: CY, IR and one per HPM counter; bit1 (TM) is hardwired 0.
  localparam logic [31:0] INH_MASK =
    32'((64'd1 << (NUM_HPM + 32'd3)) - 64'd1) & 32'hFFFF_FFFD;
  localparam logic [7:0]           PRESC_MAX = 8'(TIME_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_time;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [CNT_WIDTH-1:0] r_hpm [NUM_HPM];
  logic [31:0]          r_inh;
  logic [7:0]           r_presc;

  sel_e        w_sel;
  logic        w_hi;
  logic        w_ro;
  logic [4:0]  w_idx;
  logic [4:0]  w_hpm_n;
  logic [63:0] w_cnt64;
  logic [63:0] w_new64;
  logic [31:0] w_old32;
  logic [31:0] w_new32;
  logic        w_attempt;
  logic        w_illegal;
  logic        w_we;

  // Address decode: 0xC00/0xC80 user aliases (RO), 0xB00/0xB80 machine names (RW).
  always_comb begin
    w_idx   = csr_addr[4:0];
    w_hpm_n = w_idx - 5'd3;
    w_ro    = (csr_addr[11:8] == 4'hC);
    w_hi    = csr_addr[7];
    w_sel   = SEL_NONE;
    if (csr_addr == 12'h320) begin
      w_sel = SEL_INHIBIT;
      w_hi  = 1'b0;
    end else if ((csr_addr[11:8] == 4'hC || csr_addr[11:8] == 4'hB) &&
                 csr_addr[6:5] == 2'b00) begin
      case (w_idx)
        5'd0:    w_sel = SEL_CYCLE;
        5'd1:    if (w_ro) w_sel = SEL_TIME;
        5'd2:    w_sel = SEL_INSTRET;
        default: if (32'(w_hpm_n) < NUM_HPM) w_sel = SEL_HPM;
      endcase
    end
  end

  always_comb begin
    w_cnt64 = '0;
    case (w_sel)
      SEL_CYCLE:   w_cnt64 = 64'(r_cycle);
      SEL_TIME:    w_cnt64 = 64'(r_time);
      SEL_INSTRET: w_cnt64 = 64'(r_instret);
      SEL_HPM: begin
        for (int unsigned n = 0; n < NUM_HPM; n++) begin
          if (w_hpm_n == 5'(n)) w_cnt64 = 64'(r_hpm[n]);
        end
      end
      SEL_INHIBIT: w_cnt64 = {32'd0, r_inh};
      default: ;
    endcase

    w_old32 = w_hi ? w_cnt64[63:32] : w_cnt64[31:0];
    case (csr_op)
      2'b01:   w_new32 = csr_wdata;
      2'b10:   w_new32 = w_old32 | csr_wdata;
      2'b11:   w_new32 = w_old32 & ~csr_wdata;
      default: w_new32 = w_old32;
    endcase
    // Splice the new half into the current value so the other half is untouched.
    w_new64 = w_hi ? {w_new32, w_cnt64[31:0]} : {w_cnt64[63:32], w_new32};

    w_attempt = csr_req && (csr_op == 2'b01 || (csr_op[1] && csr_wdata != '0));
    w_illegal = csr_req && (w_sel == SEL_NONE || (w_ro && w_attempt));
    w_we      = w_attempt && !w_illegal;

    csr_illegal = rst_n && w_illegal;
    csr_rdata   = (rst_n && csr_req && !w_illegal) ? w_old32 : '0;
  end

  // A CSR write to a counter takes priority over that counter's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_time    <= '0;
      r_instret <= '0;
      r_inh     <= '0;
      r_presc   <= '0;
      for (int unsigned n = 0; n < NUM_HPM; n++) r_hpm[n] <= '0;
    end else begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_time  <= r_time + CNT_ONE;
      end else begin
        r_presc <= r_presc + 8'd1;
      end

      if (w_we && w_sel == SEL_CYCLE)
        r_cycle <= w_new64[CNT_WIDTH-1:0];
      else if (!r_inh[0])
        r_cycle <= r_cycle + CNT_ONE;

      if (w_we && w_sel == SEL_INSTRET)
        r_instret <= w_new64[CNT_WIDTH-1:0];
      else if (instret_inc && !r_inh[2])
        r_instret <= r_instret + CNT_ONE;

      for (int unsigned n = 0; n < NUM_HPM; n++) begin
        if (w_we && w_sel == SEL_HPM && w_hpm_n == 5'(n))
          r_hpm[n] <= w_new64[CNT_WIDTH-1:0];
        else if (hpm_event[n] && !r_inh[3+n])
          r_hpm[n] <= r_hpm[n] + CNT_ONE;
      end

      if (w_we && w_sel == SEL_INHIBIT)
        r_inh <= w_new32 & INH_MASK;
    end
  end

endmodule

// File: tb/tb_csr_counters.sv
// Self-checking bench for csr_counters: directed tables/sequences plus random
// accesses compared against an arithmetic model of the counter file.
module tb_csr_counters;

  localparam int unsigned NH  = 4;
  localparam int unsigned TD  = 4;
  localparam int unsigned INH = NH + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csr_req = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [1:0]    csr_op = '0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_rdata;
  logic          csr_illegal;
  logic          instret_inc = 1'b0;
  logic [NH-1:0] hpm_event = '0;

  int total = 0;
  int bad   = 0;

  csr_counters #(.NUM_HPM(NH), .CNT_WIDTH(64), .TIME_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .instret_inc(instret_inc), .hpm_event(hpm_event)
  );

  always #5 clk = ~clk;

  // Model: counter k = 0 cycle, 1 time, 2 instret, 3+n hpm n.
  longint unsigned m_cnt [NH+3];
  longint unsigned m_ticks;
  logic [31:0]     m_inh;
  logic [31:0]     g_rdata;
  logic            g_ill;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = '0;
    m[0] = 1'b1;
    for (int unsigned b = 2; b < NH + 3; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic void m_reset();
    for (int unsigned k = 0; k < NH + 3; k++) m_cnt[k] = 0;
    m_ticks = 0;
    m_inh   = '0;
  endfunction

  function automatic void m_decode(input logic [11:0] a, output bit legal, output bit ro,
                                   output int unsigned k, output bit hi);
    legal = 0; ro = 0; k = 0; hi = 0;
    if (a == 12'h320) begin legal = 1; k = INH; end
    for (int unsigned c = 0; c < NH + 3; c++) begin
      if (a == 12'hC00 + 12'(c)) begin legal = 1; ro = 1; k = c; hi = 0; end
      if (a == 12'hC80 + 12'(c)) begin legal = 1; ro = 1; k = c; hi = 1; end
      if (c != 1 && a == 12'hB00 + 12'(c)) begin legal = 1; ro = 0; k = c; hi = 0; end
      if (c != 1 && a == 12'hB80 + 12'(c)) begin legal = 1; ro = 0; k = c; hi = 1; end
    end
  endfunction

  // One clock of stimulus: drive, check combinational outputs vs model, advance model.
  task automatic cycle_op(input bit req, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd, input bit inc, input logic [NH-1:0] ev);
    bit              legal, ro, hi, att, wr;
    int unsigned     k;
    logic [31:0]     old, nv, inh_old;
    longint unsigned pre, v;
    csr_req = req; csr_addr = a; csr_op = op; csr_wdata = wd;
    instret_inc = inc; hpm_event = ev;
    #2;
    g_rdata = csr_rdata;
    g_ill   = csr_illegal;
    m_decode(a, legal, ro, k, hi);
    att = req && (op == 2'b01 || (op[1] && wd != 0));
    pre = 0;
    old = 0;
    if (legal) begin
      if (k == INH) old = m_inh;
      else begin
        pre = m_cnt[k];
        old = hi ? pre[63:32] : pre[31:0];
      end
    end
    check("model_illegal", g_ill, req && (!legal || (ro && att)));
    if (!(legal && ro && att))
      check("model_rdata", g_rdata, (req && legal) ? old : 32'd0);
    wr = req && legal && !ro && att;
    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      default: nv = old & ~wd;
    endcase
    @(posedge clk);
    if (rst_n) begin
      inh_old = m_inh;
      if (!inh_old[0]) m_cnt[0]++;
      m_ticks++;
      m_cnt[1] = m_ticks / TD;
      if (inc && !inh_old[2]) m_cnt[2]++;
      for (int unsigned n = 0; n < NH; n++)
        if (ev[n] && !inh_old[3+n]) m_cnt[3+n]++;
      if (wr) begin
        if (k == INH) m_inh = nv & inh_mask();
        else begin
          v = pre;
          if (hi) v[63:32] = nv; else v[31:0] = nv;
          m_cnt[k] = v;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a);
    cycle_op(1'b1, a, 2'b00, 32'd0, 1'b0, '0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cycle_op(1'b1, a, 2'b01, d, 1'b0, '0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle_op(1'b0, 12'h000, 2'b00, 32'd0, 1'b0, '0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wd;
    bit          exp_ill;
  } vec_t;

  vec_t            vt[$];
  logic [11:0]     mapped[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    // Outputs stay quiet while reset is held, even for illegal accesses.
    #2;
    csr_req = 1'b1; csr_addr = 12'hFFF; csr_op = 2'b01; csr_wdata = 32'h1;
    #1;
    check("rst_illegal", csr_illegal, 1'b0);
    csr_addr = 12'hC00; csr_op = 2'b00;
    #1;
    check("rst_rdata", csr_rdata, 32'd0);
    @(negedge clk);
    csr_req = 1'b0;
    rst_n = 1'b1;

    idle(10);
    rd(12'hC00); check("cycle_after_10", g_rdata, 32'd10);
    rd(12'hC80); check("cycle_hi_0", g_rdata, 32'd0);
    rd(12'hC02); check("instret_0", g_rdata, 32'd0);
    idle(3);
    rd(12'hC01); check("time_16cyc", g_rdata, 32'd4);

    vt.push_back('{12'hC00, 2'b01, 32'hDEAD, 1'b1});
    vt.push_back('{12'hC00, 2'b10, 32'h0,    1'b0});
    vt.push_back('{12'hC00, 2'b11, 32'h0,    1'b0});
    vt.push_back('{12'hC81, 2'b10, 32'h1,    1'b1});
    vt.push_back('{12'hC01, 2'b00, 32'h5,    1'b0});
    vt.push_back('{12'hB01, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hB07, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hC07, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hC86, 2'b00, 32'h0,    1'b0});
    vt.push_back('{12'hB86, 2'b11, 32'h0,    1'b0});
    vt.push_back('{12'hC87, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hC20, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hC40, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'hD00, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'h321, 2'b00, 32'h0,    1'b1});
    vt.push_back('{12'h320, 2'b00, 32'h0,    1'b0});
    vt.push_back('{12'hB80, 2'b00, 32'h0,    1'b0});
    foreach (vt[i]) begin
      cycle_op(1'b1, vt[i].addr, vt[i].op, vt[i].wd, 1'b0, '0);
      check($sformatf("tbl_ill_%0h", vt[i].addr), g_ill, vt[i].exp_ill);
      if (vt[i].exp_ill && vt[i].op == 2'b00)
        check($sformatf("tbl_rd0_%0h", vt[i].addr), g_rdata, 32'd0);
    end

    // Lo write then hi write; the carry shows up after one more increment.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    idle(1);
    rd(12'hC00); check("carry_lo", g_rdata, 32'h0);
    rd(12'hC80); check("carry_hi", g_rdata, 32'h1);

    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hC00); check("allones_lo", g_rdata, 32'hFFFF_FFFF);
    rd(12'hC80); check("wrap_hi", g_rdata, 32'h0);

    wr(12'h320, 32'h5);
    wr(12'hB00, 32'h100);
    wr(12'hB02, 32'h200);
    wr(12'hB80, 32'h0);
    wr(12'hB82, 32'h0);
    for (int i = 0; i < 3; i++) cycle_op(1'b0, 12'h0, 2'b00, 32'd0, 1'b1, '0);
    rd(12'hB00); check("inh_cycle", g_rdata, 32'h100);
    rd(12'hB02); check("inh_instret", g_rdata, 32'h200);
    rd(12'hB80); check("inh_cycle_hi", g_rdata, 32'h0);
    cycle_op(1'b1, 12'h320, 2'b11, 32'h4, 1'b0, '0);
    check("rc_old_inh", g_rdata, 32'h5);
    for (int i = 0; i < 2; i++) cycle_op(1'b0, 12'h0, 2'b00, 32'd0, 1'b1, '0);
    rd(12'hB02); check("ir_resumed", g_rdata, 32'h202);
    rd(12'hB00); check("cy_still_inh", g_rdata, 32'h100);
    cycle_op(1'b1, 12'h320, 2'b01, 32'h4, 1'b1, '0);
    cycle_op(1'b0, 12'h0, 2'b00, 32'd0, 1'b1, '0);
    rd(12'hB02); check("inh_next_cycle", g_rdata, 32'h203);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320); check("inh_mask", g_rdata, 32'h7D);
    wr(12'h320, 32'h0);

    wr(12'hB00, 32'h50);
    cycle_op(1'b1, 12'hC00, 2'b01, 32'hDEAD, 1'b0, '0);
    check("ro_write_ill", g_ill, 1'b1);
    rd(12'hC00); check("ro_write_nochg", g_rdata, 32'h51);
    cycle_op(1'b1, 12'hC00, 2'b10, 32'h0, 1'b0, '0);
    check("rs0_legal", g_ill, 1'b0);
    check("rs0_rdata", g_rdata, 32'h52);
    rd(12'hB03 + 12'(NH)); check("hpm_oob_ill", g_ill, 1'b1);
    check("hpm_oob_rd", g_rdata, 32'h0);

    cycle_op(1'b1, 12'hB02, 2'b01, 32'h7, 1'b1, '0);
    rd(12'hB02); check("wr_beats_inc", g_rdata, 32'h7);
    wr(12'hB03, 32'h0);
    wr(12'hB83, 32'h0);
    for (int i = 0; i < 5; i++) cycle_op(1'b0, 12'h0, 2'b00, 32'd0, 1'b0, 4'b0001);
    rd(12'hC03); check("hpm0_5", g_rdata, 32'h5);

    // Reset asserted in the middle of a write access.
    csr_req = 1'b1; csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", csr_rdata, 32'd0);
    check("midrst_ill", csr_illegal, 1'b0);
    m_reset();
    repeat (2) @(negedge clk);
    csr_req = 1'b0;
    rst_n = 1'b1;
    rd(12'hC00); check("post_rst_c0", g_rdata, 32'd0);
    rd(12'hC00); check("post_rst_c1", g_rdata, 32'd1);
    rd(12'hB03);
    rd(12'h320);

    mapped.push_back(12'h320);
    for (int unsigned c = 0; c < NH + 3; c++) begin
      mapped.push_back(12'hC00 + 12'(c));
      mapped.push_back(12'hC80 + 12'(c));
      if (c != 1) begin
        mapped.push_back(12'hB00 + 12'(c));
        mapped.push_back(12'hB80 + 12'(c));
      end
    end
    for (int i = 0; i < 600; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 9) < 8) a = mapped[$urandom_range(0, mapped.size() - 1)];
      else a = 12'($urandom);
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      cycle_op($urandom_range(0, 3) != 0, a, 2'($urandom_range(0, 3)), d,
               1'($urandom_range(0, 1)), NH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
